onehot_stream_encoder: RTL and testbench
========================================

Name: onehot_stream_encoder

Overview:
- Inverse of the 3-to-8 opcode decoder: accepts an 8-bit request vector and emits the index of each set bit as a 3-bit code, one code per handshake, lowest index first.
- Sits between opcode-select logic producing bit vectors and a consumer expecting binary opcodes.
- Uses valid/ready handshakes on both sides.
- Holds a latched copy of the vector and serialises it, so multi-hot inputs are handled rather than aliased.

Parameters:
- N, 8, request vector width. Must be a power of two, at least 2.
- W, 3, code width. Equals log2(N).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  block enable; when low, the block freezes and both handshakes are blocked
- req_in  input  N  request vector
- req_valid  input  1  req_in is valid
- req_ready  output  1  block can accept a vector
- code  output  W  encoded bit index (registered)
- code_valid  output  1  code is valid (registered)
- code_ready  input  1  consumer accepts code
- code_last  output  1  current code is the final one for the latched vector (registered)
- zero_err  output  1  one-cycle pulse: a vector of all zeros was accepted (registered)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pending=0
  - code=0, code_valid=0, code_last=0, zero_err=0
  - req_ready=0 while rst is high
- req_ready = en & (state==IDLE) & !rst. This is combinational from state only, with no path from req_valid.
- States:
  - IDLE
  - SERVE
- IDLE:
  - Accept occurs when req_valid & req_ready.
  - If req_in != 0 on accept:
    - pending <= req_in
    - code <= index of lowest set bit
    - code_last <= (popcount(req_in)==1)
    - code_valid <= 1
    - state <= SERVE
    - Latency: accept at cycle T gives code_valid=1 at T+1.
  - If req_in == 0 on accept: zero_err <= 1 for exactly one cycle, state stays IDLE, no code is emitted.
- SERVE:
  - code_valid is held at 1 and code is held stable until the handshake (code_valid & code_ready & en).
  - On handshake:
    - Clear the served bit in pending.
    - If the remaining pending != 0: code <= next lowest set index, code_last updated. The next code appears the following cycle, giving back-to-back throughput of 1 code per cycle.
    - If the remaining pending == 0: code_valid <= 0, code_last <= 0, state <= IDLE. req_ready rises the cycle after the last handshake.
  - req_in and req_valid are ignored in SERVE.
- en=0:
  - No state, pending, code or code_last update.
  - req_ready=0.
  - code_valid keeps its registered value, but the handshake is not counted while en=0.
- Priority: the lowest index wins (bit 0 first). Width rules: code is an unsigned W-bit index; pending is N bits.
- Reset mid-SERVE: the vector is discarded, and all outputs return to reset values immediately (asynchronously).
- zero_err is a pulse only; it does not stall the block and is cleared the next cycle.

Decomposition:
- Shared package holds:
  - state typedef {IDLE, SERVE}
  - constants N=8, W=3
  - function lowest_set_index(vector) returning W bits
  - function is_single_bit(vector)
- Natural sub-module: lsb_priority_encoder. A combinational N-to-W lowest-set-bit encoder with an any_set output. It is instantiated once on the pending-next vector.

Test Plan:
- Single-hot: req_in=8'b0010_0000 accepted with code_ready=1. Required: code=5, code_valid=1, code_last=1 at T+1; req_ready high at T+3.
- Multi-hot streaming: req_in=8'b1000_1001 with code_ready held 1. Required: codes 0, 3, 7 on consecutive cycles, code_last only with 7, then IDLE.
- Backpressure: req_in=8'b0000_0110 with code_ready=0 for 4 cycles. Required: code=1 held stable with code_valid=1; after code_ready rises, next code=2 with code_last=1.
- Zero vector: req_in=0 accepted. Required: zero_err=1 for one cycle, code_valid stays 0, req_ready stays 1.
- Enable freeze: en=0 mid-SERVE on 8'b1111_0000 with code_ready=1. Required: code stays 4, no bits cleared, req_ready=0; after en=1, codes resume 4, 5, 6, 7.
- Async reset mid-SERVE: assert rst between clock edges while code=3. Required: code_valid, code and code_last go to 0 immediately; after release, req_ready=en and the old vector is not resumed.

Source files
------------

// File: rtl/onehot_stream_encoder_pkg.sv
// Shared definitions for the one-hot stream encoder.
//
// Contents:
//   N, W               request vector width and code width (W = log2(N))
//   state_e            serialiser state {IDLE, SERVE}
//   lowest_set_index() index of the lowest set bit (0 for an all-zero vector)
//   is_single_bit()    true when exactly one bit of the vector is set
package onehot_stream_encoder_pkg;

  localparam int N = 8;
  localparam int W = $clog2(N);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  // Scan from the top down so the last hit (the lowest index) wins.
  function automatic logic [W-1:0] lowest_set_index(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves zero only for a single-hot vector.
  function automatic logic is_single_bit(input logic [N-1:0] vec);
    return (vec != '0) && ((vec & (vec - N'(1))) == '0);
  endfunction

endpackage : onehot_stream_encoder_pkg

// File: rtl/onehot_stream_encoder_lsb_priority_encoder.sv
// Combinational lowest-set-bit priority encoder.
//
// Ports:
//   vec_i      N-bit input vector
//   idx_o      W-bit index of the lowest set bit (0 when vec_i is all zero)
//   any_set_o  high when at least one bit of vec_i is set
module lsb_priority_encoder
  import onehot_stream_encoder_pkg::*;
(
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_set_o
);

  assign idx_o     = lowest_set_index(vec_i);
  assign any_set_o = |vec_i;

endmodule : lsb_priority_encoder

// File: rtl/onehot_stream_encoder.sv
// One-hot (or multi-hot) request vector to binary code serialiser.
//
// A request vector is latched on the input handshake and its set bits are
// emitted as W-bit indices, lowest first, one per output handshake.  An
// all-zero vector is accepted, flagged with a one-cycle zero_err pulse and
// produces no code.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   en          block enable; low freezes all state and blocks both handshakes
//   req_in      N-bit request vector
//   req_valid   req_in is valid
//   req_ready   block can accept a vector (combinational from state, en, rst)
//   code        registered index of the current set bit
//   code_valid  registered: code is valid
//   code_ready  consumer accepts code
//   code_last   registered: code is the final one for the latched vector
//   zero_err    registered one-cycle pulse: an all-zero vector was accepted
module onehot_stream_encoder
  import onehot_stream_encoder_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req_in,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] code,
  output logic         code_valid,
  input  logic         code_ready,
  output logic         code_last,
  output logic         zero_err
);

  state_e         state_q;
  logic [N-1:0]   pending_q;
  logic [W-1:0]   code_q;
  logic           code_valid_q;
  logic           code_last_q;
  logic           zero_err_q;

  logic [N-1:0]   served_d;   // pending with the currently presented bit cleared
  logic [N-1:0]   pending_d;  // vector the encoder looks at this cycle
  logic [W-1:0]   next_idx;
  logic           next_any;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here, an unconditional default first) so no latch is inferred.
  always_comb begin
    served_d  = pending_q;
    served_d[code_q] = 1'b0;
    pending_d = (state_q == IDLE) ? req_in : served_d;
  end

  // One encoder serves both the first code (from req_in in IDLE) and every
  // following code (from the remaining bits in SERVE).
  lsb_priority_encoder u_lsb_enc (
    .vec_i     (pending_d),
    .idx_o     (next_idx),
    .any_set_o (next_any)
  );

  // No path from req_valid, so an upstream ready/valid loop cannot form.
  assign req_ready = en & (state_q == IDLE) & ~rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: pending_q is a plain register, not a memory, so it is reset
      // along with everything else; a stale vector must never resume.
      state_q      <= IDLE;
      pending_q    <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      code_last_q  <= 1'b0;
      zero_err_q   <= 1'b0;
    end else begin
      // Pulse only: cleared every cycle unless re-armed below.
      zero_err_q <= 1'b0;
      if (en) begin
        unique case (state_q)
          IDLE: begin
            if (req_valid) begin
              if (next_any) begin
                pending_q    <= req_in;
                code_q       <= next_idx;
                code_last_q  <= is_single_bit(req_in);
                code_valid_q <= 1'b1;
                state_q      <= SERVE;
              end else begin
                zero_err_q <= 1'b1;
              end
            end
          end
          SERVE: begin
            // code_valid_q is always 1 in SERVE; the handshake needs only ready.
            if (code_ready) begin
              pending_q <= served_d;
              if (next_any) begin
                code_q      <= next_idx;
                code_last_q <= is_single_bit(served_d);
              end else begin
                code_valid_q <= 1'b0;
                code_last_q  <= 1'b0;
                state_q      <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign code_last  = code_last_q;
  assign zero_err   = zero_err_q;

endmodule : onehot_stream_encoder

// File: tb/tb_onehot_stream_encoder.sv
// Directed self-checking bench for onehot_stream_encoder.
module tb_onehot_stream_encoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req_in;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       code_last;
  logic       zero_err;

  int n_tests;
  int n_failed;

  onehot_stream_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_in     (req_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_last  (code_last),
    .zero_err   (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compares the full registered output set plus req_ready.
  task automatic check_outputs(input string tag, input logic exp_valid,
                               input logic [2:0] exp_code, input logic exp_last,
                               input logic exp_ready);
    check({tag, ".code_valid"}, 32'(code_valid), 32'(exp_valid));
    check({tag, ".code"},       32'(code),       32'(exp_code));
    check({tag, ".code_last"},  32'(code_last),  32'(exp_last));
    check({tag, ".req_ready"},  32'(req_ready),  32'(exp_ready));
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for exactly one accepting edge.
  task automatic send(input logic [7:0] vec);
    req_in    = vec;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_in    = '0;
  endtask

  initial begin
    n_tests    = 0;
    n_failed   = 0;
    rst        = 1'b1;
    en         = 1'b1;
    req_in     = '0;
    req_valid  = 1'b0;
    code_ready = 1'b0;

    // Reset state
    #2;
    check_outputs("reset", 1'b0, 3'd0, 1'b0, 1'b0);
    check("reset.zero_err", 32'(zero_err), 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset.req_ready", 32'(req_ready), 32'd1);
    tick();

    // Single-hot: bit 5
    code_ready = 1'b1;
    send(8'b0010_0000);
    check_outputs("single.T1", 1'b1, 3'd5, 1'b1, 1'b0);
    tick();
    check("single.T2.code_valid", 32'(code_valid), 32'd0);
    tick();
    check("single.T3.req_ready", 32'(req_ready), 32'd1);

    // Multi-hot streaming: bits 0, 3, 7 back to back
    send(8'b1000_1001);
    check_outputs("multi.c0", 1'b1, 3'd0, 1'b0, 1'b0);
    tick();
    check_outputs("multi.c3", 1'b1, 3'd3, 1'b0, 1'b0);
    tick();
    check_outputs("multi.c7", 1'b1, 3'd7, 1'b1, 1'b0);
    tick();
    check_outputs("multi.idle", 1'b0, 3'd7, 1'b0, 1'b1);

    // Backpressure: code 1 held for 4 cycles, then code 2 last
    code_ready = 1'b0;
    send(8'b0000_0110);
    for (int i = 0; i < 4; i++) begin
      check_outputs($sformatf("bp.hold%0d", i), 1'b1, 3'd1, 1'b0, 1'b0);
      tick();
    end
    code_ready = 1'b1;
    check_outputs("bp.hold_last", 1'b1, 3'd1, 1'b0, 1'b0);
    tick();
    check_outputs("bp.c2", 1'b1, 3'd2, 1'b1, 1'b0);
    tick();
    check_outputs("bp.idle", 1'b0, 3'd2, 1'b0, 1'b1);

    // Zero vector: one-cycle zero_err, no code, stays ready
    check("zero.pre_ready", 32'(req_ready), 32'd1);
    send(8'b0000_0000);
    check("zero.err_pulse", 32'(zero_err), 32'd1);
    check("zero.code_valid", 32'(code_valid), 32'd0);
    check("zero.req_ready", 32'(req_ready), 32'd1);
    tick();
    check("zero.err_clear", 32'(zero_err), 32'd0);
    check("zero.code_valid2", 32'(code_valid), 32'd0);

    // Enable freeze mid-SERVE on bits 4..7
    send(8'b1111_0000);
    check_outputs("freeze.c4", 1'b1, 3'd4, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outputs($sformatf("freeze.hold%0d", i), 1'b1, 3'd4, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick();
    check_outputs("freeze.c5", 1'b1, 3'd5, 1'b0, 1'b0);
    tick();
    check_outputs("freeze.c6", 1'b1, 3'd6, 1'b0, 1'b0);
    tick();
    check_outputs("freeze.c7", 1'b1, 3'd7, 1'b1, 1'b0);
    tick();
    check_outputs("freeze.idle", 1'b0, 3'd7, 1'b0, 1'b1);
    en = 1'b0;
    #1;
    check("idle_en0.req_ready", 32'(req_ready), 32'd0);
    en = 1'b1;
    #1;

    // Async reset mid-SERVE while code=3
    code_ready = 1'b0;
    send(8'b0001_1000);
    check_outputs("arst.c3", 1'b1, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs("arst.during", 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    code_ready = 1'b1;
    #1;
    check("arst.release_ready", 32'(req_ready), 32'd1);
    tick();
    check_outputs("arst.no_resume1", 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    check_outputs("arst.no_resume2", 1'b0, 3'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule : tb_onehot_stream_encoder
